// File: rtl/multicycle_ctrl_if.sv
// Control bundle between multicycle_ctrl (master) and the RV32I multi-cycle datapath (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               Zero;
  logic               Sign;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ImmSrc;
  logic [3:0]         ALUControl;
  logic               Illegal;
  logic [STATE_W-1:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero, Sign,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, Illegal, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Sign,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, Illegal, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM and ALU decoder for the multi-cycle RV32I datapath.
// Define MC_BRANCH_EXT_EN to decode all six conditional branches; otherwise only beq is legal.
module multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master cif
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StLui      = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluPass = 4'b1001;
  localparam logic [3:0] AluSra  = 4'b1111;

  state_e     state_q, state_d;
  logic [3:0] alu_arith, alu_branch, alu_control;
  logic       branch_ok, taken;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic       unused_sign;

  // Sign is exported for observation only; branches resolve on Zero alone.
  assign unused_sign = cif.Sign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Shared R-type / I-type decode; only R-type may select sub.
  always_comb begin
    alu_arith = AluAdd;
    unique case (cif.funct3)
      3'b000: alu_arith = (cif.op == OpRType && cif.funct7b5) ? AluSub : AluAdd;
      3'b001: alu_arith = AluSll;
      3'b010: alu_arith = AluSlt;
      3'b011: alu_arith = AluSltu;
      3'b100: alu_arith = AluXor;
      3'b101: alu_arith = cif.funct7b5 ? AluSra : AluSrl;
      3'b110: alu_arith = AluOr;
      3'b111: alu_arith = AluAnd;
    endcase
  end

  always_comb begin
    alu_branch = AluSub;
    branch_ok  = 1'b1;
    taken      = cif.Zero;
`ifdef MC_BRANCH_EXT_EN
    // slt/sltu yield 1 when the condition holds, so "less" branches take on !Zero.
    case (cif.funct3)
      3'b000: begin alu_branch = AluSub;  taken = cif.Zero;  end
      3'b001: begin alu_branch = AluSub;  taken = !cif.Zero; end
      3'b100: begin alu_branch = AluSlt;  taken = !cif.Zero; end
      3'b101: begin alu_branch = AluSlt;  taken = cif.Zero;  end
      3'b110: begin alu_branch = AluSltu; taken = !cif.Zero; end
      3'b111: begin alu_branch = AluSltu; taken = cif.Zero;  end
      default: branch_ok = 1'b0;
    endcase
`else
    branch_ok = (cif.funct3 == 3'b000);
`endif
  end

  always_comb begin
    cif.ImmSrc = 3'b000;
    case (cif.op)
      OpStore:  cif.ImmSrc = 3'b001;
      OpBranch: cif.ImmSrc = 3'b010;
      OpJal:    cif.ImmSrc = 3'b011;
      OpLui:    cif.ImmSrc = 3'b100;
      default:  cif.ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = StFetch;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = AluAdd;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (cif.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIAlu:          state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          OpBranch: begin
            state_d = branch_ok ? StBranch : StFetch;
            illegal = !branch_ok;
          end
          default:         illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (cif.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_arith;
        state_d     = StAluWb;
      end
      StExecuteI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_arith;
        state_d     = StAluWb;
      end
      StAluWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a   = 2'b10;
        alu_control = alu_branch;
        pc_write    = taken;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StLui: begin
        alu_src_b   = 2'b01;
        alu_control = AluPass;
        state_d     = StAluWb;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset holds the state at FETCH; gating the strobes keeps FETCH from writing meanwhile.
  assign cif.PCWrite    = pc_write & ~reset;
  assign cif.IRWrite    = ir_write & ~reset;
  assign cif.MemWrite   = mem_write & ~reset;
  assign cif.RegWrite   = reg_write & ~reset;
  assign cif.Illegal    = illegal & ~reset;
  assign cif.AdrSrc     = adr_src;
  assign cif.ResultSrc  = result_src;
  assign cif.ALUSrcA    = alu_src_a;
  assign cif.ALUSrcB    = alu_src_b;
  assign cif.ALUControl = alu_control;
  assign cif.State      = STATE_W'(state_q);

endmodule
